// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller.
//   state_e       : FSM state encoding (also driven out on the debug state port)
//   OP_*          : opcode values the controller recognises
//   ALU_*         : ALUControl encodings driven to the datapath ALU
//   ALUOP_*       : ALUOp encodings passed from the FSM to the ALU decoder
//   imm_src_of()  : immediate-format select derived from the opcode
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  localparam logic [6:0] OP_LW    = 7'd3;
  localparam logic [6:0] OP_ITYPE = 7'd19;
  localparam logic [6:0] OP_SW    = 7'd35;
  localparam logic [6:0] OP_RTYPE = 7'd51;
  localparam logic [6:0] OP_BEQ   = 7'd99;
  localparam logic [6:0] OP_JAL   = 7'd111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Immediate format: S-type for stores, B-type for branches, J-type for jal,
  // I-type for everything else.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return 2'b01;
      OP_BEQ:  return 2'b10;
      OP_JAL:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU decoder.
//   alu_op      : operation class from the FSM (add / sub / decode funct fields)
//   funct3      : instruction funct3 field
//   op_b5       : opcode bit 5 (1 for R-type, 0 for I-type)
//   funct7_b5   : instruction bit 30
//   alu_control : ALU operation select
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op_b5,
  input  logic       funct7_b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type with bit 30 set is a subtract; addi ignores bit 30.
          3'b000:  alu_control = (op_b5 && funct7_b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V subset controller (lw, sw, R-type, I-type ALU, jal, beq).
//   clk, rst                : clock, synchronous active-low reset
//   op, funct3, funct7_bit5 : instruction fields from the instruction register
//   Zero                    : ALU zero flag, used by beq
//   mem_ready               : unified memory access complete
//   PCWrite .. RegWrite     : datapath enables / selects
//   ResultSrc .. ImmSrc     : 2-bit mux selects
//   ALUControl              : ALU operation
//   illegal                 : sticky unknown-opcode flag
//   state                   : current FSM state, for debug
//
// Memory handshake: the controller presents a request (AdrSrc, MemWrite,
// IRWrite) in FETCH, MEMREAD or MEMWRITE and holds it unchanged on every
// cycle mem_ready is 0; the access completes at the rising edge where
// mem_ready is 1, and only then does the FSM leave that state.
//
// The state is the only FSM flop. Outputs are decoded from state_q so they
// are valid in the same cycle as the state; IRWrite/PCWrite also depend on
// mem_ready and Zero because those qualify the write in that very cycle.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_bit5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       pc_update;
  logic       branch;
  logic [1:0] alu_op;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_ITYPE:     state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default: begin
            illegal_d = 1'b1;
            state_d   = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
          end
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output decode; anything not set for a state stays 0.
  always_comb begin
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = ALUOP_ADD;
    pc_update = 1'b0;
    branch    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        pc_update = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB:    RegWrite = 1'b1;
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  mc_alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op_b5       (op[5]),
    .funct7_b5   (funct7_bit5),
    .alu_control (ALUControl)
  );

  assign PCWrite = pc_update | (branch & Zero);
  assign ImmSrc  = imm_src_of(op);
  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7_bit5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic       illegal;
  logic [3:0] state;

  logic       pc_write_n, adr_src_n, mem_write_n, ir_write_n, reg_write_n;
  logic [1:0] result_src_n, alu_src_a_n, alu_src_b_n, imm_src_n;
  logic [2:0] alu_control_n;
  logic       illegal_n;
  logic [3:0] state_n;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_bit5(funct7_bit5),
    .Zero(zero), .mem_ready(mem_ready),
    .PCWrite(pc_write), .AdrSrc(adr_src), .MemWrite(mem_write), .IRWrite(ir_write),
    .RegWrite(reg_write), .ResultSrc(result_src), .ALUSrcA(alu_src_a),
    .ALUSrcB(alu_src_b), .ImmSrc(imm_src), .ALUControl(alu_control),
    .illegal(illegal), .state(state)
  );

  // Same stimulus, illegal opcodes treated as no-ops.
  multicycle_controller #(.TRAP_ON_ILLEGAL(1'b0)) dut_n (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_bit5(funct7_bit5),
    .Zero(zero), .mem_ready(mem_ready),
    .PCWrite(pc_write_n), .AdrSrc(adr_src_n), .MemWrite(mem_write_n), .IRWrite(ir_write_n),
    .RegWrite(reg_write_n), .ResultSrc(result_src_n), .ALUSrcA(alu_src_a_n),
    .ALUSrcB(alu_src_b_n), .ImmSrc(imm_src_n), .ALUControl(alu_control_n),
    .illegal(illegal_n), .state(state_n)
  );

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // ---------------- behavioural model ----------------
  // Each instruction is a route of states chosen at decode; FETCH, MEMREAD
  // and MEMWRITE wait for mem_ready, TRAP waits for reset.
  logic [3:0] m_state = 4'd0;
  logic       m_ill = 1'b0;
  logic [3:0] exp_q[$];

  task automatic plan_route(input logic [6:0] o);
    case (o)
      7'd3:    begin exp_q.push_back(4'd2); exp_q.push_back(4'd3); exp_q.push_back(4'd4); end
      7'd35:   begin exp_q.push_back(4'd2); exp_q.push_back(4'd5); end
      7'd51:   begin exp_q.push_back(4'd6); exp_q.push_back(4'd7); end
      7'd19:   begin exp_q.push_back(4'd8); exp_q.push_back(4'd7); end
      7'd111:  begin exp_q.push_back(4'd9); exp_q.push_back(4'd7); end
      7'd99:   exp_q.push_back(4'd10);
      default: begin m_ill = 1'b1; exp_q.push_back(4'd11); end
    endcase
  endtask

  task automatic model_step();
    if (rst === 1'b0) begin
      m_state = 4'd0;
      m_ill   = 1'b0;
      exp_q.delete();
    end else if ((m_state == 4'd0 || m_state == 4'd3 || m_state == 4'd5) && !mem_ready) begin
      m_state = m_state;
    end else if (m_state == 4'd11) begin
      m_state = 4'd11;
    end else if (m_state == 4'd0) begin
      m_state = 4'd1;
    end else begin
      if (m_state == 4'd1) plan_route(op);
      m_state = (exp_q.size() > 0) ? exp_q.pop_front() : 4'd0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Expected control bundle:
  // {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl}
  function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic [6:0] o,
                                           input logic [2:0] f3, input logic f7b,
                                           input logic z, input logic mr);
    logic pcu, br, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb, aop, imm;
    logic [2:0] alu;
    {pcu, br, adr, mw, irw, rw} = 6'b0;
    {rs, sa, sb, aop} = 8'b0;
    case (st)
      4'd0:  begin rs = 2; sb = 2; irw = mr; pcu = mr; end
      4'd1:  begin sa = 1; sb = 1; end
      4'd2:  begin sa = 2; sb = 1; end
      4'd3:  adr = 1;
      4'd4:  begin rs = 1; rw = 1; end
      4'd5:  begin adr = 1; mw = 1; end
      4'd6:  begin sa = 2; aop = 2; end
      4'd7:  rw = 1;
      4'd8:  begin sa = 2; sb = 1; aop = 2; end
      4'd9:  begin sa = 1; sb = 2; pcu = 1; end
      4'd10: begin sa = 2; aop = 1; br = 1; end
      default: ;
    endcase
    imm = (o == 7'd35) ? 2'd1 : (o == 7'd99) ? 2'd2 : (o == 7'd111) ? 2'd3 : 2'd0;
    alu = 3'd0;
    if (aop == 2'd1) alu = 3'd1;
    else if (aop == 2'd2) begin
      if (f3 == 3'd0)      alu = (o[5] && f7b) ? 3'd1 : 3'd0;
      else if (f3 == 3'd2) alu = 3'd5;
      else if (f3 == 3'd6) alu = 3'd3;
      else if (f3 == 3'd7) alu = 3'd2;
    end
    return {pcu | (br & z), adr, mw, irw, rw, rs, sa, sb, imm, alu};
  endfunction

  function automatic logic [15:0] act_ctrl();
    return {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
            alu_src_a, alu_src_b, imm_src, alu_control};
  endfunction

  // ---------------- scoreboard compare (every cycle) ----------------
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      logic [15:0] e, a;
      e = exp_ctrl(m_state, op, funct3, funct7_bit5, zero, mem_ready);
      a = act_ctrl();
      checks++;
      if (state !== m_state) begin
        failures++;
        $display("FAIL state t=%0t actual=%0d required=%0d", $time, state, m_state);
      end
      checks++;
      if (illegal !== m_ill) begin
        failures++;
        $display("FAIL illegal t=%0t actual=%0b required=%0b", $time, illegal, m_ill);
      end
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL ctrl t=%0t state=%0d actual=%h required=%h", $time, m_state, a, e);
      end
    end
  end

  // ---------------- literal checks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  logic [3:0]  tr_state[16];
  logic [3:0]  tr_state_n[16];
  logic [15:0] tr_ctrl[16];
  logic        tr_ill[16];
  logic        tr_ill_n[16];

  // Record n cycles; mem_ready for cycle i comes from mr_pat[i].
  task automatic trace(input int n, input logic [15:0] mr_pat);
    for (int i = 0; i < n; i++) begin
      mem_ready = mr_pat[i];
      @(negedge clk); #1;
      tr_state[i]   = state;
      tr_state_n[i] = state_n;
      tr_ctrl[i]    = act_ctrl();
      tr_ill[i]     = illegal;
      tr_ill_n[i]   = illegal_n;
      @(posedge clk); #1;
    end
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    op = o; funct3 = f3; funct7_bit5 = f7; zero = z;
  endtask

  // Random driver: one cycle of random handshake/flag activity.
  task automatic step_rand(input logic r);
    rst       = r;
    mem_ready = ($urandom_range(0, 3) != 0);
    zero      = $urandom_range(0, 1);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [6:0] legal_ops[6];
    int cnt;
    legal_ops[0] = 7'd3;  legal_ops[1] = 7'd35; legal_ops[2] = 7'd51;
    legal_ops[3] = 7'd19; legal_ops[4] = 7'd111; legal_ops[5] = 7'd99;

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cmp_en = 1'b1;

    // Reset state: FETCH values, waiting then completing
    mem_ready = 1'b0;
    @(negedge clk); #1;
    chk("reset_state", {28'd0, state}, 32'd0);
    chk("reset_illegal", {31'd0, illegal}, 32'd0);
    chk("fetch_wait_ctrl", {16'd0, act_ctrl()}, 32'h0440);
    mem_ready = 1'b1;
    #1;
    chk("fetch_ready_ctrl", {16'd0, act_ctrl()}, 32'h9440);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    trace(4, 16'h0000);  // finish the decoded op=0 instruction (illegal path)
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // addi x8,x0,6
    set_instr(7'd19, 3'd0, 1'b0, 1'b0);
    trace(5, 16'hFFEF);
    chk("addi_states", {12'd0, tr_state[0], tr_state[1], tr_state[2], tr_state[3], tr_state[4]}, 32'h01870);
    chk("addi_alu", {29'd0, tr_ctrl[2][2:0]}, 32'd0);
    chk("addi_regwrite", {27'd0, tr_ctrl[0][11], tr_ctrl[1][11], tr_ctrl[2][11], tr_ctrl[3][11], tr_ctrl[4][11]}, 32'b00010);

    // sub, then add (bit 30 clear)
    set_instr(7'd51, 3'd0, 1'b1, 1'b0);
    trace(5, 16'hFFEF);
    chk("sub_state", {28'd0, tr_state[2]}, 32'd6);
    chk("sub_alu", {29'd0, tr_ctrl[2][2:0]}, 32'd1);
    set_instr(7'd51, 3'd0, 1'b0, 1'b0);
    trace(5, 16'hFFEF);
    chk("add_alu", {29'd0, tr_ctrl[2][2:0]}, 32'd0);

    // beq taken / not taken
    set_instr(7'd99, 3'd0, 1'b0, 1'b1);
    trace(4, 16'hFFF7);
    chk("beq_taken_states", {16'd0, tr_state[0], tr_state[1], tr_state[2], tr_state[3]}, 32'h01A0);
    chk("beq_taken_pcwrite", {31'd0, tr_ctrl[2][15]}, 32'd1);
    set_instr(7'd99, 3'd0, 1'b0, 1'b0);
    trace(4, 16'hFFF7);
    chk("beq_nt_states", {16'd0, tr_state[0], tr_state[1], tr_state[2], tr_state[3]}, 32'h01A0);
    chk("beq_nt_pcwrite", {31'd0, tr_ctrl[2][15]}, 32'd0);

    // lw with three wait cycles in MEMREAD
    set_instr(7'd3, 3'd2, 1'b0, 1'b0);
    trace(9, 16'hFEC7);
    cnt = 0;
    for (int i = 0; i < 9; i++) if (tr_state[i] == 4'd3) cnt++;
    chk("lw_memread_cycles", cnt, 32'd4);
    chk("lw_memwb_state", {28'd0, tr_state[7]}, 32'd4);
    chk("lw_memwb_regwrite", {31'd0, tr_ctrl[7][11]}, 32'd1);
    chk("lw_memwb_resultsrc", {30'd0, tr_ctrl[7][10:9]}, 32'd1);
    chk("lw_back_fetch", {28'd0, tr_state[8]}, 32'd0);

    // sw with two wait cycles in MEMWRITE
    set_instr(7'd35, 3'd2, 1'b0, 1'b0);
    trace(7, 16'hFFA7);
    chk("sw_memwrite_run", {29'd0, tr_ctrl[3][13], tr_ctrl[4][13], tr_ctrl[5][13]}, 32'b111);
    cnt = 0;
    for (int i = 0; i < 7; i++) if (tr_ctrl[i][13]) cnt++;
    chk("sw_memwrite_count", cnt, 32'd3);
    chk("sw_back_fetch", {28'd0, tr_state[6]}, 32'd0);

    // illegal opcode: trap vs no-op variants, then reset out of TRAP
    set_instr(7'h7F, 3'd0, 1'b0, 1'b0);
    trace(4, 16'hFFFF);
    chk("illegal_trap", {28'd0, tr_state[2]}, 32'd11);
    chk("illegal_trap_hold", {28'd0, tr_state[3]}, 32'd11);
    chk("illegal_flag", {31'd0, tr_ill[3]}, 32'd1);
    chk("illegal_noop_state", {28'd0, tr_state_n[2]}, 32'd0);
    chk("illegal_noop_flag", {31'd0, tr_ill_n[2]}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk); #1;
    chk("trap_reset_state", {28'd0, state}, 32'd0);
    chk("trap_reset_illegal", {31'd0, illegal}, 32'd0);
    @(posedge clk); #1;

    // reset in MEMADR
    set_instr(7'd3, 3'd2, 1'b0, 1'b0);
    trace(2, 16'hFFFF);
    rst = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk); #1;
    chk("memadr_before_reset", {28'd0, state}, 32'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    chk("memadr_reset_fetch", {28'd0, state}, 32'd0);
    @(posedge clk); #1;

    // randomized instruction stream against the model
    for (int n = 0; n < 400; n++) begin
      int guard;
      if (m_state == 4'd11) begin
        step_rand(1'b1);
        step_rand(1'b0);
      end
      if ($urandom_range(0, 9) == 0) op = 7'($urandom_range(0, 127));
      else op = legal_ops[$urandom_range(0, 5)];
      funct3 = 3'($urandom_range(0, 7));
      funct7_bit5 = $urandom_range(0, 1);
      guard = 0;
      do begin
        step_rand(($urandom_range(0, 59) != 0));
        guard++;
      end while (m_state != 4'd0 && m_state != 4'd11 && guard < 64);
      checks++;
      if (guard >= 64) begin
        failures++;
        $display("FAIL instr_timeout n=%0d actual_state=%0d required=0", n, state);
      end
    end

    step_rand(1'b0);
    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-low.
REQ-002 Parameter TRAP_ON_ILLEGAL, default 1: 1 sends an unknown opcode to TRAP; 0 treats it as a no-op and returns to FETCH.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-low reset (0 = reset).
REQ-005 op  input  7  instruction opcode field, taken from the instruction register.
REQ-006 funct3  input  3  instruction funct3 field.
REQ-007 funct7_bit5  input  1  instruction bit 30.
REQ-008 Zero  input  1  ALU zero flag.
REQ-009 mem_ready  input  1  unified memory access complete.
REQ-010 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  output  1 each  datapath enables and selects.
REQ-011 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  output  2 each  mux selects.
REQ-012 ALUControl  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-013 illegal  output  1  sticky flag, set when an unknown opcode is decoded.
REQ-014 state  output  4  current state encoding, for debug.

Function
REQ-015 States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10, TRAP=11.
REQ-016 Outputs not listed for a state SHALL be 0 in that state.
REQ-017 PCWrite SHALL equal PCUpdate OR (Branch AND Zero).
REQ-018 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
- IRWrite=1 and PCUpdate=1 only while mem_ready=1.
- Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
REQ-019 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by op:
- 3 or 35 -> MEMADR
- 51 -> EXECUTER
- 19 -> EXECUTEI
- 111 -> JAL
- 99 -> BEQ
- other -> TRAP (TRAP_ON_ILLEGAL=1) or FETCH (TRAP_ON_ILLEGAL=0); set illegal in both cases.
REQ-020 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state: op=3 -> MEMREAD, else MEMWRITE.
REQ-021 MEMREAD: AdrSrc=1, ResultSrc=00. Holds while mem_ready=0; goes to MEMWB when mem_ready=1.
REQ-022 MEMWB: ResultSrc=01, RegWrite=1. Next state FETCH.
REQ-023 MEMWRITE: AdrSrc=1, MemWrite=1, held for the whole wait. Goes to FETCH on mem_ready=1.
REQ-024 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state ALUWB.
REQ-025 EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state ALUWB.
REQ-026 ALUWB: ResultSrc=00, RegWrite=1. Next state FETCH.
REQ-027 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next state ALUWB.
REQ-028 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next state FETCH.
REQ-029 TRAP: all enables 0; stays in TRAP until reset.
REQ-030 ImmSrc SHALL be combinational from op in every state: 35->01, 99->10, 111->11, else 00.
REQ-031 ALU decoder inputs: ALUOp, funct3, op[5], funct7_bit5.
- ALUOp 00 -> add; 01 -> sub.
- ALUOp 10, funct3 000: sub when {op[5],funct7_bit5}=11, else add.
- ALUOp 10, funct3 010 -> slt; 110 -> or; 111 -> and; any other funct3 -> add.
REQ-032 Each instruction's latency in cycles, with mem_ready=1 throughout:
- lw 5; sw 4; R-type 4; I-type 4; jal 4; beq 3.
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.

Reset
REQ-033 While rst=0 at a clock edge, the next state SHALL be FETCH and illegal SHALL be cleared.
REQ-034 Reset SHALL take priority over any transition, including mid-instruction and in TRAP.
REQ-035 After reset, outputs SHALL be the FETCH values per REQ-018.

Structure
REQ-036 A shared package mc_pkg SHALL hold:
- the state enum;
- the opcode constants 3, 19, 35, 51, 99, 111;
- the ALUControl encodings;
- the ALUOp encodings.
REQ-037 The ALU decoder SHALL be a separate combinational sub-module, mc_alu_decoder; the FSM stays in multicycle_controller.

Verification
REQ-038 op=19, funct3=000, mem_ready=1 (addi x8,x0,6 = 0x00600413) -> states 0,1,8,7,0; ALUControl=000 in EXECUTEI; RegWrite=1 only in ALUWB.
REQ-039 op=51, funct3=000, funct7_bit5=1 (sub 0x409409B3) -> ALUControl=001 in EXECUTER; funct7_bit5=0 gives 000.
REQ-040 op=99, Zero=1 -> PCWrite=1 in BEQ. Repeat with Zero=0 -> PCWrite=0; state returns to FETCH after 3 cycles in both runs.
REQ-041 op=3, mem_ready held 0 for 3 cycles in MEMREAD -> 4 cycles in MEMREAD, then MEMWB with RegWrite=1, ResultSrc=01.
REQ-042 op=35 with mem_ready=0 for 2 cycles -> MemWrite=1 for 3 consecutive cycles, then FETCH.
REQ-043 op=0x7F -> TRAP with illegal=1 held; rst=0 for one cycle -> state=0, illegal=0; rst=0 during MEMADR -> FETCH next cycle.
